// File: rtl/cordic_vectoring_rtl.sv
// ----------------------------------------------------------------------------
// cordic_vectoring_rtl
//
// Iterative CORDIC core in vectoring mode. It converts a Cartesian vector
// (x_in, y_in) in fixpoint(2:10) to polar form:
//   angle_out = atan2(y, x) in radians, fixpoint(3:10), range +/-pi (+/-3217)
//   mag_out   = sqrt(x^2 + y^2),        fixpoint(3:10), always >= 0
// It performs one micro-rotation per clock. It shares the 11-entry arctangent
// table and the 0.6073 gain constant with the rotation-mode core.
//
// Ports:
//   clock      in   1     single clock, rising edge
//   reset      in   1     synchronous, active-high; aborts any job in flight
//   start      in   1     request, level-sampled in IDLE
//   x_in       in   W     signed x, fixpoint(2:10)
//   y_in       in   W     signed y, fixpoint(2:10)
//   ready_out  out  1     result valid, held until the next accepted start
//   angle_out  out  W+1   signed angle, fixpoint(3:10)
//   mag_out    out  W+1   signed magnitude, fixpoint(3:10)
//
// Timing: the edge that samples start is edge 0, and ready_out rises after
// edge 13. The latency is the same for every input, including (0, 0).
// ----------------------------------------------------------------------------
module cordic_vectoring_rtl #(
    parameter int W         = 12,
    parameter int FXP_SHIFT = 10
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic signed [W-1:0] x_in,
    input  logic signed [W-1:0] y_in,
    output logic                ready_out,
    output logic signed [W:0]   angle_out,
    output logic signed [W:0]   mag_out
);

    localparam int XW    = W + 3;   // x/y datapath width, room for gain growth
    localparam int ZW    = W + 1;   // angle accumulator width
    localparam int PW    = 24;      // gain product width
    localparam int NITER = 11;

    // pi/2 in fixpoint(3:10)
    localparam logic signed [ZW-1:0] HALF_PI = ZW'(1608);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ITER,
        S_GAIN,
        S_OUT,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             iter_q,  iter_d;
    logic signed [XW-1:0]   x_q,     x_d;
    logic signed [XW-1:0]   y_q,     y_d;
    logic signed [ZW-1:0]   z_q,     z_d;
    logic                   zero_q,  zero_d;
    logic signed [PW-1:0]   prod_q,  prod_d;
    logic                   ready_q, ready_d;
    logic signed [ZW-1:0]   angle_q, angle_d;
    logic signed [ZW-1:0]   mag_q,   mag_d;

    // Inputs are widened before any negation, so -(-2048) is exact.
    logic signed [XW-1:0]   x_ext, y_ext;
    logic signed [XW-1:0]   x_sh,  y_sh;
    logic signed [ZW-1:0]   atan_val;
    logic signed [PW-1:0]   x_wide, gain_prod;
    logic                   unused_prod_bits;

    assign x_ext = {{(XW-W){x_in[W-1]}}, x_in};
    assign y_ext = {{(XW-W){y_in[W-1]}}, y_in};

    assign x_sh = x_q >>> iter_q;
    assign y_sh = y_q >>> iter_q;

    // K = 621 = 512 + 128 - 32 + 16 - 4 + 1, i.e. about 0.6073 * 1024
    assign x_wide    = {{(PW-XW){x_q[XW-1]}}, x_q};
    assign gain_prod = (x_wide <<< 9) + (x_wide <<< 7) - (x_wide <<< 5)
                     + (x_wide <<< 4) - (x_wide <<< 2) + x_wide;

    // The magnitude takes only bits [FXP_SHIFT +: W+1] of the product.
    // Its bound of 2897 means the top bit is never significant.
    assign unused_prod_bits = ^{prod_q[PW-1:FXP_SHIFT+W+1], prod_q[FXP_SHIFT-1:0]};

    // atan(2^-i) in Q2.10
    always_comb begin
        atan_val = '0;
        case (iter_q)
            4'd0:    atan_val = ZW'(804);
            4'd1:    atan_val = ZW'(475);
            4'd2:    atan_val = ZW'(251);
            4'd3:    atan_val = ZW'(127);
            4'd4:    atan_val = ZW'(64);
            4'd5:    atan_val = ZW'(32);
            4'd6:    atan_val = ZW'(16);
            4'd7:    atan_val = ZW'(8);
            4'd8:    atan_val = ZW'(4);
            4'd9:    atan_val = ZW'(2);
            4'd10:   atan_val = ZW'(1);
            default: atan_val = '0;
        endcase
    end

    // NOTE: every next-state signal gets its hold value first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        zero_d  = zero_q;
        prod_d  = prod_q;
        ready_d = ready_q;
        angle_d = angle_q;
        mag_d   = mag_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ready_d = 1'b0;
                    iter_d  = '0;
                    zero_d  = (x_in == '0) && (y_in == '0);
                    state_d = S_ITER;
                    // Rotate the vector into the right half-plane by +/-90
                    // degrees. y = 0 with negative x takes the +pi branch.
                    if (!x_in[W-1]) begin
                        x_d = x_ext;
                        y_d = y_ext;
                        z_d = '0;
                    end else if (!y_in[W-1]) begin
                        x_d = y_ext;
                        y_d = -x_ext;
                        z_d = HALF_PI;
                    end else begin
                        x_d = -y_ext;
                        y_d = x_ext;
                        z_d = -HALF_PI;
                    end
                end
            end

            S_ITER: begin
                // Drive y toward zero. Both updates use the pre-update x and y.
                if (!y_q[XW-1]) begin
                    x_d = x_q + y_sh;
                    y_d = y_q - x_sh;
                    z_d = z_q + atan_val;
                end else begin
                    x_d = x_q - y_sh;
                    y_d = y_q + x_sh;
                    z_d = z_q - atan_val;
                end
                if (iter_q == 4'(NITER - 1)) begin
                    state_d = S_GAIN;
                end else begin
                    iter_d = iter_q + 4'd1;
                end
            end

            S_GAIN: begin
                prod_d  = gain_prod;
                state_d = S_OUT;
            end

            S_OUT: begin
                // The iterations give a nonzero angle for (0, 0), so the
                // outputs are forced to zero for that input.
                if (zero_q) begin
                    angle_d = '0;
                    mag_d   = '0;
                end else begin
                    angle_d = z_q;
                    mag_d   = prod_q[FXP_SHIFT +: W+1];
                end
                ready_d = 1'b1;
                state_d = S_DONE;
            end

            S_DONE: begin
                // A held start must not retrigger. start has to drop first.
                if (!start) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments, so every register
    // samples the values from before the edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
            ready_q <= 1'b0;
            angle_q <= '0;
            mag_q   <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            ready_q <= ready_d;
            angle_q <= angle_d;
            mag_q   <= mag_d;
        end
    end

    // NOTE: the datapath registers have no reset. They are always loaded in
    // IDLE before they are read, and a reset returns the FSM to IDLE.
    always_ff @(posedge clock) begin
        x_q    <= x_d;
        y_q    <= y_d;
        z_q    <= z_d;
        zero_q <= zero_d;
        prod_q <= prod_d;
    end

    assign ready_out = ready_q;
    assign angle_out = angle_q;
    assign mag_out   = mag_q;

endmodule
